status_led_ctrl: RTL

STATUS_LED_CTRL -- requirements
Module: status_led_ctrl

---
 rtl/status_led_pkg.sv | 29 ++
 rtl/lock_qualifier.sv | 47 ++++
 rtl/status_led_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/status_led_pkg.sv
// Shared definitions for the status LED controller.
// Contents: mode encodings, field widths and small frame helpers used by the top level.
package status_led_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned CODE_W = 4;
    // Holds 2*C+3 for the largest code (33).
    localparam int unsigned SLOT_W = CODE_W + 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_BLINK = 3'd2,
        MODE_FLASH = 3'd3,
        MODE_FAULT = 3'd4
    } led_mode_e;

    // Last slot index of a flash frame: 2*C+3.
    function automatic logic [SLOT_W-1:0] frame_last(input logic [CODE_W-1:0] code);
        return {1'b0, code, 1'b0} + SLOT_W'(3);
    endfunction

    // Flash pattern: lit on even slots below 2*C.
    function automatic logic flash_on(input logic [SLOT_W-1:0] slot,
                                      input logic [CODE_W-1:0] code);
        return (slot < {1'b0, code, 1'b0}) && !slot[0];
    endfunction

endpackage

// File: rtl/lock_qualifier.sv
// PLL lock qualifier: two-flop synchroniser followed by a saturating run-length filter.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low reset
//   i_lock   - raw PLL lock, asynchronous to i_clk
//   o_locked - registered; high while LOCK_FILT consecutive synchronised high cycles are seen
module lock_qualifier #(
    parameter int unsigned LOCK_FILT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lock,
    output logic o_locked
);

    localparam int unsigned FILT_W = $clog2(LOCK_FILT + 1);
    localparam logic [FILT_W-1:0] FiltMax = FILT_W'(LOCK_FILT);

    logic              sync1_q, sync2_q;
    logic [FILT_W-1:0] filt_q, filt_d;
    logic              locked_q;

    always_comb begin
        filt_d = '0;
        if (sync2_q) begin
            filt_d = (filt_q == FiltMax) ? filt_q : filt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            filt_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            sync1_q  <= i_lock;
            sync2_q  <= sync1_q;
            filt_q   <= filt_d;
            // Registered from the next filter value so it tracks filt_q exactly.
            locked_q <= (filt_d == FiltMax);
        end
    end

    assign o_locked = locked_q;

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED controller driven from a lock-gated free-running divider.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low reset
//   i_lock   - raw PLL lock (asynchronous)
//   i_mode   - per-channel 3-bit mode, channel k at [3k+2:3k]
//   i_code   - per-channel 4-bit flash count, channel k at [4k+3:4k]
//   o_led    - registered LED drives (ACTIVE_LOW=1: 0 means lit)
//   o_locked - qualified lock flag
//   o_tick   - one-cycle pulse at every slot boundary while locked
module status_led_ctrl
    import status_led_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned DIV_W      = 25,
    parameter int unsigned LOCK_FILT  = 16,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_lock,
    input  logic [MODE_W*N_CH-1:0] i_mode,
    input  logic [CODE_W*N_CH-1:0] i_code,
    output logic [N_CH-1:0]        o_led,
    output logic                   o_locked,
    output logic                   o_tick
);

    logic locked;

    lock_qualifier #(
        .LOCK_FILT (LOCK_FILT)
    ) u_lock_qualifier (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_lock   (i_lock),
        .o_locked (locked)
    );

    assign o_locked = locked;

    // Divider and slot tick
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    always_comb begin
        div_d  = locked ? div_q + 1'b1 : '0;
        // Low bits about to wrap: the next state starts a new slot.
        tick_d = locked && (&div_q[DIV_W-4:0]);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    // A tick registered in the last locked cycle must not leak into the unlocked state.
    assign o_tick = tick_q & locked;

    // Per-channel frame state
    logic [MODE_W-1:0] mode_q [N_CH];
    logic [CODE_W-1:0] code_q [N_CH];
    logic [CODE_W-1:0] code_d [N_CH];
    logic [SLOT_W-1:0] slot_q [N_CH];
    logic [SLOT_W-1:0] slot_d [N_CH];
    logic [N_CH-1:0]   lit;
    logic [N_CH-1:0]   led_q;

    // Slot counters run regardless of mode so a switch into FLASH joins the live frame.
    // While unlocked the counter sits at slot 0 and the code latch follows i_code,
    // so the first frame after lock uses the code present at lock time.
    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            slot_d[k] = slot_q[k];
            code_d[k] = code_q[k];
            if (!locked) begin
                slot_d[k] = '0;
                code_d[k] = i_code[CODE_W*k +: CODE_W];
            end else if (tick_d) begin
                if (slot_q[k] == frame_last(code_q[k])) begin
                    slot_d[k] = '0;
                    code_d[k] = i_code[CODE_W*k +: CODE_W];
                end else begin
                    slot_d[k] = slot_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            lit[k] = 1'b0;
            case (mode_q[k])
                MODE_ON:    lit[k] = 1'b1;
                MODE_BLINK: lit[k] = div_q[DIV_W-1];
                MODE_FLASH: lit[k] = flash_on(slot_q[k], code_q[k]);
                MODE_FAULT: lit[k] = !locked;
                default:    lit[k] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                mode_q[k] <= '0;
                code_q[k] <= '0;
                slot_q[k] <= '0;
            end
            led_q <= {N_CH{ACTIVE_LOW}};
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                mode_q[k] <= i_mode[MODE_W*k +: MODE_W];
                code_q[k] <= code_d[k];
                slot_q[k] <= slot_d[k];
            end
            led_q <= lit ^ {N_CH{ACTIVE_LOW}};
        end
    end

    assign o_led = led_q;

endmodule
